// File: rtl/bank128_wr_n.sv
// 128 x n storage bank with registered read select feeding a 128:1 mux, single write port and sequenced clear.
// Optional: define BANK_WRCNT_EN to add a saturating accepted-write counter on wr_cnt_o.
module bank128_wr_n #(
  parameter int unsigned n       = 4,
  parameter int unsigned address = 7,
  parameter int unsigned m       = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [address-1:0] wr_addr_i,
  input  logic [n-1:0]       wr_data_i,
  input  logic               clr_req_i,
  input  logic               rd_en_i,
  input  logic [address-1:0] rd_addr_i,
  output logic [n-1:0]       data_o [0:m-1],
  output logic [address-1:0] sel_o,
  output logic               rd_valid_o,
  output logic               wr_ack_o,
`ifdef BANK_WRCNT_EN
  output logic [7:0]         wr_cnt_o,
`endif
  output logic               busy_o
);

  localparam int unsigned CntW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e             state_q;
  logic [address-1:0] cnt_q;
  logic [address-1:0] sel_q;
  logic [n-1:0]       mem_q [0:m-1];
  logic               rd_valid_q;
  logic               wr_ack_q;
  logic               busy_q;

  logic wr_accept_c;
  logic rd_accept_c;
  logic clr_start_c;

  // A clear request in IDLE wins over a coincident write; reads are only served in IDLE.
  assign clr_start_c = (state_q == IDLE) && clr_req_i;
  assign wr_accept_c = (state_q == IDLE) && wr_en_i && !clr_req_i;
  assign rd_accept_c = (state_q == IDLE) && rd_en_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(m); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= rd_accept_c;
      wr_ack_q   <= wr_accept_c;
      if (rd_accept_c) begin
        sel_q <= rd_addr_i;
      end
      if (wr_accept_c) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          // One word per edge; the counter wraps back to 0 on the final edge.
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + address'(1);
          if (cnt_q == address'(m - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BANK_WRCNT_EN
  logic [CntW-1:0] wr_cnt_q;
  logic [CntW-1:0] wr_cnt_d;

  // Saturating count of accepted writes, restarted by each clear.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (clr_start_c) begin
      wr_cnt_d = '0;
    end else if (wr_accept_c && (wr_cnt_q != {CntW{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start_c ^ (CntW == 0);
`endif

  assign data_o     = mem_q;
  assign sel_o      = sel_q;
  assign rd_valid_o = rd_valid_q;
  assign wr_ack_o   = wr_ack_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_bank128_wr_n.sv
// Scoreboard bench for bank128_wr_n: directed stimulus pushes expected reads/acks, a negedge monitor checks them.
module tb_bank128_wr_n;

  logic       clk_i;
  logic       rst_i;
  logic       wr_en_i;
  logic [6:0] wr_addr_i;
  logic [3:0] wr_data_i;
  logic       clr_req_i;
  logic       rd_en_i;
  logic [6:0] rd_addr_i;
  logic [3:0] data_o [0:127];
  logic [6:0] sel_o;
  logic       rd_valid_o;
  logic       wr_ack_o;
  logic       busy_o;
`ifdef BANK_WRCNT_EN
  logic [7:0] wr_cnt_o;
`endif

  bank128_wr_n #(.n(4), .address(7), .m(128)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .clr_req_i  (clr_req_i),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .data_o     (data_o),
    .sel_o      (sel_o),
    .rd_valid_o (rd_valid_o),
    .wr_ack_o   (wr_ack_o),
`ifdef BANK_WRCNT_EN
    .wr_cnt_o   (wr_cnt_o),
`endif
    .busy_o     (busy_o)
  );

  typedef struct packed {
    logic [6:0] addr;
    logic [3:0] data;
  } rd_exp_t;

  rd_exp_t    rd_q [$];
  int         ack_pend;
  int         checks;
  int         errors;
  logic [3:0] exp_mem [0:127];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented read/ack is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (rd_valid_o) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_sel", int'(sel_o), int'(e.addr));
        chk("rd_data", int'(data_o[e.addr]), int'(e.data));
      end
    end
    if (wr_ack_o) begin
      if (ack_pend == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        ack_pend--;
        chk("ack_seen", 1, 1 - 0 * ack_pend);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accepted IDLE write; the model and ack scoreboard are updated at issue.
  task automatic do_write(input int a, input int d);
    wr_en_i   = 1'b1;
    wr_addr_i = 7'(a);
    wr_data_i = 4'(d);
    exp_mem[a] = 4'(d);
    ack_pend++;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_exp_t e;
    rd_en_i   = 1'b1;
    rd_addr_i = 7'(a);
    e.addr = 7'(a);
    e.data = exp_mem[a];
    rd_q.push_back(e);
    tick();
    rd_en_i = 1'b0;
  endtask

  // Called right after the entry edge; walks the 128 clear edges.
  task automatic run_clear(input bit inject, input int sel_exp);
    int nz;
    chk("busy_entry", int'(busy_o), 1);
    for (int c = 1; c <= 128; c++) begin
      if (inject && c == 11) begin
        wr_en_i = 1'b1; wr_addr_i = 7'd127; wr_data_i = 4'hA;
        rd_en_i = 1'b1; rd_addr_i = 7'd3;
      end
      tick();
      if (inject && c == 11) begin
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        chk("clr_wr_ack", int'(wr_ack_o), 0);
        chk("clr_rd_valid", int'(rd_valid_o), 0);
        chk("clr_sel_hold", int'(sel_o), sel_exp);
      end
      exp_mem[c-1] = 4'h0;
      chk("clr_word", int'(data_o[c-1]), 0);
      if (c < 128) begin
        chk("clr_untouched", int'(data_o[c]), int'(exp_mem[c]));
        chk("busy_during", int'(busy_o), 1);
      end else begin
        chk("busy_exit", int'(busy_o), 0);
      end
    end
    nz = 0;
    for (int i = 0; i < 128; i++) if (data_o[i] != 4'h0) nz++;
    chk("clr_all_zero", nz, 0);
  endtask

  initial begin
    int nz;
    checks = 0; errors = 0; ack_pend = 0;
    for (int i = 0; i < 128; i++) exp_mem[i] = 4'h0;
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    clr_req_i = 1'b0; rd_en_i = 1'b0; rd_addr_i = '0;
    #23;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ack", int'(wr_ack_o), 0);
    chk("rst_rd_valid", int'(rd_valid_o), 0);
    chk("rst_sel", int'(sel_o), 0);
    nz = 0;
    for (int i = 0; i < 128; i++) if (data_o[i] != 4'h0) nz++;
    chk("rst_words", nz, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Write then read address 10.
    do_write(10, 5);
    chk("t1_ack_pulse", int'(wr_ack_o), 1);
    do_read(10);
    chk("t1_ack_drop", int'(wr_ack_o), 0);
    chk("t1_sel", int'(sel_o), 10);
    tick();
    chk("t1_rd_valid_drop", int'(rd_valid_o), 0);

    // Same-edge write and read of address 20: write-first.
    do_write(20, 3);
    wr_en_i = 1'b1; wr_addr_i = 7'd20; wr_data_i = 4'h9;
    exp_mem[20] = 4'h9; ack_pend++;
    do_read(20);
    wr_en_i = 1'b0;
    chk("t4_data", int'(data_o[20]), 9);
    tick();

    // Fill pattern then clear, with a write and read injected mid-clear.
    for (int a = 0; a < 128; a++) do_write(a, a & 15);
    tick();
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    run_clear(1'b1, 20);
    tick();

    // Clear request coincident with a write: the write is dropped.
    do_write(5, 2);
    tick();
    clr_req_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 7'd5; wr_data_i = 4'h7;
    tick();
    clr_req_i = 1'b0; wr_en_i = 1'b0;
    chk("t5_no_ack", int'(wr_ack_o), 0);
    run_clear(1'b0, 20);
    chk("t5_word5", int'(data_o[5]), 0);
    tick();

    // Asynchronous reset part-way through a clear.
    do_write(100, 6);
    do_write(50, 12);
    do_read(50);
    tick();
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    chk("t6_busy_mid", int'(busy_o), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_sel", int'(sel_o), 0);
    chk("t6_word100", int'(data_o[100]), 0);
    chk("t6_word50", int'(data_o[50]), 0);
    for (int i = 0; i < 128; i++) exp_mem[i] = 4'h0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("t6_idle_after", int'(busy_o), 0);
    do_read(100);
    chk("t6_read_sel", int'(sel_o), 100);
    tick();

`ifdef BANK_WRCNT_EN
    chk("cnt_rst", int'(wr_cnt_o), 0);
    for (int i = 0; i < 3; i++) do_write(i, 1);
    chk("cnt_3", int'(wr_cnt_o), 3);
    for (int i = 3; i < 300; i++) do_write(i % 128, i & 15);
    chk("cnt_sat", int'(wr_cnt_o), 255);
    tick();
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    chk("cnt_clr", int'(wr_cnt_o), 0);
    run_clear(1'b0, 100);
    tick();
`endif

    tick();
    chk("rd_q_drained", rd_q.size(), 0);
    chk("ack_drained", ack_pend, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
